// File: rtl/sram_responder_if.sv
// sram_responder_if
// Pin-level bundle of the 256Kx16 asynchronous SRAM as seen by the test
// controller (master) and the behavioural responder (slave).
//   SRAM_A      18  word address
//   SRAM_DB_I   16  write data from the pad
//   SRAM_DB_O   16  read data toward the pad
//   SRAM_DB_OE   2  pad drive enable per byte lane ([1]=DB[15:8])
//   SRAM_*_N     1  active-low chip/write/output/byte strobes
interface sram_responder_if;
  logic [17:0] SRAM_A;
  logic [15:0] SRAM_DB_I;
  logic [15:0] SRAM_DB_O;
  logic [1:0]  SRAM_DB_OE;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        SRAM_CE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;

  modport master (
    output SRAM_A, SRAM_DB_I, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N,
    input  SRAM_DB_O, SRAM_DB_OE
  );

  modport slave (
    input  SRAM_A, SRAM_DB_I, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N,
    output SRAM_DB_O, SRAM_DB_OE
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder
// Behavioural stand-in for the external 256Kx16 asynchronous SRAM. Pins are
// registered once, writes are committed into an internal array, and reads
// are answered READ_LAT edges after the address was sampled, with optional
// read-data corruption and activity statistics.
//   SRAM_sys_clk  system clock, rising edge
//   SRAM_rst      synchronous active-high reset
//   sram          pin bundle (slave side)
//   fault_en/addr/mask  XOR mask applied to reads at one word address
//   stat_clr      synchronous clear of wr_count, rd_count, conflict
//   wr_count/rd_count   saturating event counters
//   conflict      sticky: WE_N and OE_N both low with CE_N low
module sram_responder #(
  parameter int MEM_AW   = 10,
  parameter int READ_LAT = 2
) (
  input  logic            SRAM_sys_clk,
  input  logic            SRAM_rst,
  sram_responder_if.slave sram,
  input  logic            fault_en,
  input  logic [17:0]     fault_addr,
  input  logic [15:0]     fault_mask,
  input  logic            stat_clr,
  output logic [31:0]     wr_count,
  output logic [31:0]     rd_count,
  output logic            conflict
);
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int PIPE_N = READ_LAT - 1;

  // Input stage
  logic [17:0] r_s_a;
  logic [15:0] r_s_db;
  logic        r_s_we_n, r_s_oe_n, r_s_ce_n, r_s_ub_n, r_s_lb_n;
  logic        r_s_fault_en;
  logic [17:0] r_s_fault_addr;
  logic [15:0] r_s_fault_mask;

  // Array and read path
  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rd_word;
  logic [15:0] r_rd_xor;
  logic [1:0]  r_rd_oe;
  logic [15:0] r_pipe_db [PIPE_N];
  logic [1:0]  r_pipe_oe [PIPE_N];

  // Statistics
  logic [31:0] r_wr_count;
  logic [31:0] r_rd_count;
  logic        r_conflict;

  logic              w_is_wr;
  logic              w_is_rd;
  logic              w_is_conf;
  logic [MEM_AW-1:0] w_idx;
  logic              w_fault_hit;
  logic [1:0]        w_rd_oe;
  logic [15:0]       w_s1_db;
  logic              w_unused_hi;

  // WE_N wins over OE_N, so a conflicting cycle is a write.
  assign w_is_wr     = ~r_s_ce_n & ~r_s_we_n;
  assign w_is_rd     = ~r_s_ce_n &  r_s_we_n & ~r_s_oe_n;
  assign w_is_conf   = ~r_s_ce_n & ~r_s_we_n & ~r_s_oe_n;
  assign w_idx       = r_s_a[MEM_AW-1:0];
  assign w_fault_hit = r_s_fault_en & (w_idx == r_s_fault_addr[MEM_AW-1:0]);
  assign w_rd_oe     = {w_is_rd & ~r_s_ub_n, w_is_rd & ~r_s_lb_n};
  // Disabled lanes are forced to zero before entering the delay line.
  assign w_s1_db     = (r_rd_word ^ r_rd_xor) & {{8{r_rd_oe[1]}}, {8{r_rd_oe[0]}}};
  // Address bits above MEM_AW alias and are deliberately ignored.
  assign w_unused_hi = ^{r_s_a, r_s_fault_addr};

  // Register every pin and fault control once; reset parks strobes inactive
  // so no cycle sampled during reset is acted upon.
  always_ff @(posedge SRAM_sys_clk) begin
    if (SRAM_rst) begin
      r_s_a          <= 18'h0;
      r_s_db         <= 16'h0;
      r_s_we_n       <= 1'b1;
      r_s_oe_n       <= 1'b1;
      r_s_ce_n       <= 1'b1;
      r_s_ub_n       <= 1'b1;
      r_s_lb_n       <= 1'b1;
      r_s_fault_en   <= 1'b0;
      r_s_fault_addr <= 18'h0;
      r_s_fault_mask <= 16'h0;
    end else begin
      r_s_a          <= sram.SRAM_A;
      r_s_db         <= sram.SRAM_DB_I;
      r_s_we_n       <= sram.SRAM_WE_N;
      r_s_oe_n       <= sram.SRAM_OE_N;
      r_s_ce_n       <= sram.SRAM_CE_N;
      r_s_ub_n       <= sram.SRAM_UB_N;
      r_s_lb_n       <= sram.SRAM_LB_N;
      r_s_fault_en   <= fault_en;
      r_s_fault_addr <= fault_addr;
      r_s_fault_mask <= fault_mask;
    end
  end

  // Byte-lane write commit and synchronous array read (contents never reset).
  always_ff @(posedge SRAM_sys_clk) begin
    if (!SRAM_rst && w_is_wr) begin
      if (!r_s_ub_n) begin
        r_mem[w_idx][15:8] <= r_s_db[15:8];
      end
      if (!r_s_lb_n) begin
        r_mem[w_idx][7:0] <= r_s_db[7:0];
      end
    end
    r_rd_word <= r_mem[w_idx];
  end

  // First read stage: lane enables and fault mask travel with the array read.
  always_ff @(posedge SRAM_sys_clk) begin
    if (SRAM_rst) begin
      r_rd_oe  <= 2'b00;
      r_rd_xor <= 16'h0;
    end else begin
      r_rd_oe  <= w_rd_oe;
      r_rd_xor <= w_fault_hit ? r_s_fault_mask : 16'h0;
    end
  end

  // Delay line bringing the response out exactly READ_LAT edges after sampling.
  always_ff @(posedge SRAM_sys_clk) begin
    if (SRAM_rst) begin
      for (int i = 0; i < PIPE_N; i++) begin
        r_pipe_db[i] <= 16'h0;
        r_pipe_oe[i] <= 2'b00;
      end
    end else begin
      r_pipe_db[0] <= w_s1_db;
      r_pipe_oe[0] <= r_rd_oe;
      for (int i = 1; i < PIPE_N; i++) begin
        r_pipe_db[i] <= r_pipe_db[i-1];
        r_pipe_oe[i] <= r_pipe_oe[i-1];
      end
    end
  end

  assign sram.SRAM_DB_O  = r_pipe_db[PIPE_N-1];
  assign sram.SRAM_DB_OE = r_pipe_oe[PIPE_N-1];

  // Saturating counters and sticky conflict flag; a clear drops same-edge events.
  always_ff @(posedge SRAM_sys_clk) begin
    if (SRAM_rst || stat_clr) begin
      r_wr_count <= 32'h0;
      r_rd_count <= 32'h0;
      r_conflict <= 1'b0;
    end else begin
      if (w_is_wr && (r_wr_count != 32'hFFFF_FFFF)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
      if (w_is_rd && (r_rd_count != 32'hFFFF_FFFF)) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_is_conf) begin
        r_conflict <= 1'b1;
      end
    end
  end

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
  assign conflict = r_conflict;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
// Directed bench for sram_responder. A word-level model (memory array,
// response schedule keyed by edge number, plain counters) is advanced at
// each rising edge and compared with the DUT at every falling edge;
// literal expectations pin the model at the key points.
module tb_sram_responder;
  localparam int AW = 10;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fault_en = 1'b0;
  logic [17:0] fault_addr = 18'h0;
  logic [15:0] fault_mask = 16'h0;
  logic        stat_clr = 1'b0;
  logic [31:0] wr_count;
  logic [31:0] rd_count;
  logic        conflict;

  sram_responder_if bus();

  sram_responder #(.MEM_AW(AW), .READ_LAT(RL)) dut (
    .SRAM_sys_clk (clk),
    .SRAM_rst     (rst),
    .sram         (bus),
    .fault_en     (fault_en),
    .fault_addr   (fault_addr),
    .fault_mask   (fault_mask),
    .stat_clr     (stat_clr),
    .wr_count     (wr_count),
    .rd_count     (rd_count),
    .conflict     (conflict)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [15:0] m_mem [1024];
  logic [15:0] q_db [16];
  logic [1:0]  q_oe [16];
  int          cyc = 0;
  logic        pw_v = 1'b0;
  logic [9:0]  pw_a;
  logic [15:0] pw_d;
  logic        pw_ub, pw_lb;
  logic        ev_wr = 1'b0, ev_rd = 1'b0, ev_cf = 1'b0;
  logic [31:0] m_wr = 32'h0, m_rd = 32'h0;
  logic        m_cf = 1'b0;
  logic [15:0] cur_db = 16'h0;
  logic [1:0]  cur_oe = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one rising edge using the pins as sampled there.
  task automatic model_edge();
    logic [15:0] w;
    logic [1:0]  oe;
    if (pw_v && !rst) begin
      if (pw_ub) m_mem[pw_a][15:8] = pw_d[15:8];
      if (pw_lb) m_mem[pw_a][7:0]  = pw_d[7:0];
    end
    pw_v = 1'b0;
    if (rst || stat_clr) begin
      m_wr = 32'h0; m_rd = 32'h0; m_cf = 1'b0;
    end else begin
      if (ev_wr && m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 32'd1;
      if (ev_rd && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 32'd1;
      if (ev_cf) m_cf = 1'b1;
    end
    ev_wr = 1'b0; ev_rd = 1'b0; ev_cf = 1'b0;
    if (rst) begin
      for (int j = 0; j <= RL; j++) begin
        q_db[(cyc + j) % 16] = 16'h0;
        q_oe[(cyc + j) % 16] = 2'b00;
      end
    end else if (!bus.SRAM_CE_N) begin
      if (!bus.SRAM_WE_N) begin
        ev_wr = 1'b1;
        ev_cf = !bus.SRAM_OE_N;
        pw_v  = 1'b1;
        pw_a  = bus.SRAM_A[9:0];
        pw_d  = bus.SRAM_DB_I;
        pw_ub = !bus.SRAM_UB_N;
        pw_lb = !bus.SRAM_LB_N;
      end else if (!bus.SRAM_OE_N) begin
        ev_rd = 1'b1;
        w = m_mem[bus.SRAM_A[9:0]];
        if (fault_en && bus.SRAM_A[9:0] == fault_addr[9:0]) w = w ^ fault_mask;
        oe = {!bus.SRAM_UB_N, !bus.SRAM_LB_N};
        w = w & {{8{oe[1]}}, {8{oe[0]}}};
        q_db[(cyc + RL) % 16] = w;
        q_oe[(cyc + RL) % 16] = oe;
      end
    end
    cur_db = q_db[cyc % 16];
    cur_oe = q_oe[cyc % 16];
    q_db[cyc % 16] = 16'h0;
    q_oe[cyc % 16] = 2'b00;
    cyc++;
  endtask

  task automatic check_cycle();
    chk("cyc_db", {16'h0, bus.SRAM_DB_O}, {16'h0, cur_db});
    chk("cyc_oe", {30'h0, bus.SRAM_DB_OE}, {30'h0, cur_oe});
    chk("cyc_wr", wr_count, m_wr);
    chk("cyc_rd", rd_count, m_rd);
    chk("cyc_cf", {31'h0, conflict}, {31'h0, m_cf});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic put(input logic [17:0] a, input logic [15:0] d, input logic we_n,
                     input logic oe_n, input logic ce_n, input logic ub_n, input logic lb_n);
    bus.SRAM_A = a; bus.SRAM_DB_I = d;
    bus.SRAM_WE_N = we_n; bus.SRAM_OE_N = oe_n; bus.SRAM_CE_N = ce_n;
    bus.SRAM_UB_N = ub_n; bus.SRAM_LB_N = lb_n;
    step();
  endtask

  task automatic drive_wr(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
    put(a, d, 1'b0, 1'b1, 1'b0, ub_n, lb_n);
  endtask

  task automatic drive_rd(input logic [17:0] a, input logic ub_n, input logic lb_n);
    put(a, 16'h0, 1'b1, 1'b0, 1'b0, ub_n, lb_n);
  endtask

  task automatic drive_idle();
    put(18'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  // One read, then wait until exactly RL edges after its sample and check literals.
  task automatic read_lit(input string name, input logic [17:0] a, input logic ub_n, input logic lb_n,
                          input logic [15:0] exp_d, input logic [1:0] exp_oe);
    drive_rd(a, ub_n, lb_n);
    for (int i = 0; i < RL; i++) drive_idle();
    chk({name, "_db"}, {16'h0, bus.SRAM_DB_O}, {16'h0, exp_d});
    chk({name, "_oe"}, {30'h0, bus.SRAM_DB_OE}, {30'h0, exp_oe});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin q_db[i] = 16'h0; q_oe[i] = 2'b00; end
    for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0;
    bus.SRAM_A = 18'h0; bus.SRAM_DB_I = 16'h0;
    bus.SRAM_WE_N = 1'b1; bus.SRAM_OE_N = 1'b1; bus.SRAM_CE_N = 1'b1;
    bus.SRAM_UB_N = 1'b1; bus.SRAM_LB_N = 1'b1;

    // Power-on reset
    rst = 1'b1;
    repeat (3) step();
    chk("por_oe", {30'h0, bus.SRAM_DB_OE}, 32'h0);
    chk("por_wr", wr_count, 32'h0);
    rst = 1'b0;

    // Write sweep, then back-to-back read sweep
    for (int i = 0; i < 16; i++) drive_wr(i[17:0], (i % 2 == 0) ? 16'hAA55 : 16'h55AA, 1'b0, 1'b0);
    drive_idle();
    chk("wr_sweep_cnt", wr_count, 32'd16);
    for (int i = 0; i < 16; i++) drive_rd(i[17:0], 1'b0, 1'b0);
    for (int i = 0; i < RL; i++) drive_idle();
    chk("rd_sweep_cnt", rd_count, 32'd16);
    read_lit("sweep_a3", 18'd3, 1'b0, 1'b0, 16'h55AA, 2'b11);

    // Byte lanes, read immediately after write
    drive_wr(18'd5, 16'h1234, 1'b0, 1'b0);
    drive_wr(18'd5, 16'hABCD, 1'b1, 1'b0);
    read_lit("lane_full", 18'd5, 1'b0, 1'b0, 16'h12CD, 2'b11);
    read_lit("lane_hi", 18'd5, 1'b0, 1'b1, 16'h1200, 2'b10);

    // Fault injection at word 7
    fault_en = 1'b1; fault_addr = 18'd7; fault_mask = 16'h0001;
    for (int i = 0; i < 16; i++) drive_rd(i[17:0], 1'b0, 1'b0);
    read_lit("fault_a7", 18'd7, 1'b0, 1'b0, 16'h55AB, 2'b11);
    read_lit("fault_a6", 18'd6, 1'b0, 1'b0, 16'hAA55, 2'b11);
    fault_en = 1'b0;

    // Conflict: write wins, no drive, sticky flag
    put(18'd3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_idle();
    chk("conf_set", {31'h0, conflict}, 32'h1);
    read_lit("conf_data", 18'd3, 1'b0, 1'b0, 16'hBEEF, 2'b11);
    stat_clr = 1'b1;
    drive_idle();
    stat_clr = 1'b0;
    chk("clr_cf", {31'h0, conflict}, 32'h0);
    chk("clr_wr", wr_count, 32'h0);
    chk("clr_rd", rd_count, 32'h0);

    // Reset held 3 cycles during an active read stream
    put(18'd4, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_rd(18'd1, 1'b0, 1'b0);
    drive_rd(18'd2, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive_rd(i[17:0] + 18'd3, 1'b0, 1'b0);
    rst = 1'b0;
    drive_rd(18'd6, 1'b0, 1'b0);
    chk("rst_oe", {30'h0, bus.SRAM_DB_OE}, 32'h0);
    chk("rst_db", {16'h0, bus.SRAM_DB_O}, 32'h0);
    chk("rst_wr", wr_count, 32'h0);
    chk("rst_rd", rd_count, 32'h0);
    chk("rst_cf", {31'h0, conflict}, 32'h0);
    for (int i = 0; i <= RL; i++) drive_idle();

    // Read counter saturation
    #1;
    force dut.r_rd_count = 32'hFFFF_FFFE;
    m_rd = 32'hFFFF_FFFE;
    #1;
    release dut.r_rd_count;
    for (int i = 0; i < 3; i++) drive_rd(i[17:0], 1'b0, 1'b0);
    for (int i = 0; i < RL; i++) drive_idle();
    chk("rd_sat", rd_count, 32'hFFFF_FFFF);

    // Address aliasing above MEM_AW
    drive_wr(18'h00400, 16'hC3A5, 1'b0, 1'b0);
    read_lit("alias_a0", 18'h00000, 1'b0, 1'b0, 16'hC3A5, 2'b11);
    read_lit("alias_hi", 18'h3FC00, 1'b0, 1'b0, 16'hC3A5, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable behavioural responder for the 256K×16 asynchronous SRAM pin interface driven by the SRAM test controller. It samples the controller's address, strobes and write data on the system clock and stores writes in an internal block-RAM array. It answers reads on a split data bus that the top level turns into a tri-state pad. It sits on the board-less/loopback build and in simulation, and provides byte lanes, fault injection for exercising the controller's error counter, and activity statistics.

## Interface
Parameters:
- MEM_AW, 10: implemented address bits; SRAM_A[17:MEM_AW] ignored (aliasing); legal 4..18
- READ_LAT, 2: clock edges from sampling a read to valid SRAM_DB_O; legal 2..7

Ports:
- SRAM_sys_clk  in  1  system clock; all logic on rising edge
- SRAM_rst  in  1  synchronous, active-high reset
- SRAM_A  in  18  SRAM address from controller
- SRAM_DB_I  in  16  write data from pad
- SRAM_DB_O  out  16  read data to pad
- SRAM_DB_OE  out  2  pad drive enable; [1]=DB[15:8], [0]=DB[7:0]
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  in  1 each  active-low strobes
- fault_en  in  1  enable read-data corruption
- fault_addr  in  18  word address to corrupt (compared on MEM_AW low bits)
- fault_mask  in  16  XOR mask applied to read data at fault_addr
- stat_clr  in  1  synchronous clear of statistics
- wr_count  out  32  write cycles accepted, saturating
- rd_count  out  32  read cycles answered, saturating
- conflict  out  1  sticky: WE_N and OE_N sampled low together with CE_N low

## Operation
- Input stage: all pin inputs registered once (s_*) every edge; no other use of raw pins.
- Cycle classification from s_* only:
  - WRITE: CE_N=0, WE_N=0. WE_N has priority over OE_N.
  - READ: CE_N=0, WE_N=1, OE_N=0.
  - IDLE: otherwise.
- WRITE: mem[s_A[MEM_AW-1:0]] byte-written; high byte if UB_N=0, low byte if LB_N=0. Both high: no change, still counted. Level-sensitive: every WRITE cycle commits, so address stepping each clock with WE_N held low writes consecutive words.
- READ: synchronous array read, then pipeline to READ_LAT. SRAM_DB_O = word ^ (fault_mask if fault_en and s_A[MEM_AW-1:0]==fault_addr[MEM_AW-1:0], else 0). fault_* sampled with the address stage.
- SRAM_DB_OE[1] = READ & !UB_N, SRAM_DB_OE[0] = READ & !LB_N, delayed identically to data. Disabled lanes: SRAM_DB_O lane forced 0.
- Counters: wr_count +1 per WRITE cycle, rd_count +1 per READ cycle, both hold at 32'hFFFF_FFFF. conflict set on WE_N=0 & OE_N=0 & CE_N=0.
- stat_clr clears wr_count, rd_count and conflict; an event in the same cycle is discarded.
- Array contents are NOT reset; reset only clears pipeline, outputs and statistics.

## Timing
- Pins at edge t enter s_* at edge t. A WRITE commits at edge t+1. A READ drives SRAM_DB_O/SRAM_DB_OE after edge t+READ_LAT.
- Read-after-write, same address, write sampled at t, read sampled at t+1 or later: read returns the new data. No bypass is needed because the commit precedes the array read.
- Back-to-back READs at different addresses give one result per clock, fully pipelined.
- A READ→IDLE transition drops SRAM_DB_OE READ_LAT edges after the IDLE sample. There is no early turn-off.
- Counters update at edge t+1 for events sampled at t.
- Reset values after any edge with SRAM_rst=1: SRAM_DB_O=0, SRAM_DB_OE=0, wr_count=0, rd_count=0, conflict=0, all pipeline valids 0. Reset mid-read cancels every in-flight response. Reset mid-write loses only the writes not yet committed.
- Address aliasing: A and A+2^MEM_AW map to the same word.

## Test plan
- Reset: hold SRAM_rst 3 cycles during an active READ -> SRAM_DB_OE=0, SRAM_DB_O=0, counters 0 on the first post-reset cycle.
- Write sweep: WE_N low, A=0..15 one per clock, data alternating 16'hAA55/16'h55AA -> wr_count=16. A read sweep then returns the same pattern with OE=2'b11 exactly READ_LAT edges after each sampled address; rd_count=16.
- Byte lanes: write 16'h1234 to A=5, then 16'hABCD with UB_N=1 -> read A=5 returns 16'h12CD. A read with LB_N=1 -> OE=2'b10, DB_O=16'h1200.
- Fault: fault_en=1, fault_addr=7, fault_mask=16'h0001, pattern as above -> only A=7 returns 16'hAA54 or 16'h55AB. Controller-in-loop run ends with SRAM_error=1.
- Conflict/priority: WE_N=0, OE_N=0 at A=3 with data 16'hBEEF -> conflict=1, word written, OE stays 0. stat_clr -> conflict=0, counters 0.
- Saturation/aliasing: force rd_count to 32'hFFFF_FFFE, issue 3 reads -> holds 32'hFFFF_FFFF. Write A=18'h00400 with MEM_AW=10 -> read A=0 returns that data.
